// File: rtl/comet_ii_pkg.sv
// Shared COMET II ALU definitions: op codes, FR bit positions, and sequencer states.
package comet_ii_pkg;

  localparam logic [3:0] OP_CPA  = 4'b0000;
  localparam logic [3:0] OP_CPL  = 4'b0001;
  localparam logic [3:0] OP_SLL  = 4'b0010;
  localparam logic [3:0] OP_SRL  = 4'b0011;
  localparam logic [3:0] OP_SLA  = 4'b0100;
  localparam logic [3:0] OP_SRA  = 4'b0101;
  localparam logic [3:0] OP_LD   = 4'b0111;
  localparam logic [3:0] OP_ADDA = 4'b1000;
  localparam logic [3:0] OP_SUBA = 4'b1001;
  localparam logic [3:0] OP_ADDL = 4'b1010;
  localparam logic [3:0] OP_SUBL = 4'b1011;
  localparam logic [3:0] OP_AND  = 4'b1100;
  localparam logic [3:0] OP_OR   = 4'b1101;
  localparam logic [3:0] OP_XOR  = 4'b1110;
  localparam logic [3:0] OP_NOP  = 4'b1111;

  localparam int FR_OF = 2;
  localparam int FR_SF = 1;
  localparam int FR_ZF = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SLA) || (op == OP_SRA) || (op == OP_SLL) || (op == OP_SRL);
  endfunction

endpackage

// File: rtl/comet_ii_shift_step.sv
// One-bit shift step for SLA/SRA/SLL/SRL; returns the shifted value and the bit that fell out.
module comet_ii_shift_step
  import comet_ii_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] val,
  output logic [WIDTH-1:0] nxt,
  output logic             shout
);

  // Select the single-bit move for the requested shift flavour
  always_comb begin
    nxt   = val;
    shout = 1'b0;
    case (op)
      OP_SLA: begin
        // Sign bit is pinned; the magnitude field moves left and loses bit WIDTH-2
        nxt   = {val[WIDTH-1], val[WIDTH-3:0], 1'b0};
        shout = val[WIDTH-2];
      end
      OP_SRA: begin
        nxt   = {val[WIDTH-1], val[WIDTH-1:1]};
        shout = val[0];
      end
      OP_SLL: begin
        nxt   = {val[WIDTH-2:0], 1'b0};
        shout = val[WIDTH-1];
      end
      OP_SRL: begin
        nxt   = {1'b0, val[WIDTH-1:1]};
        shout = val[0];
      end
      default: begin
        nxt   = val;
        shout = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/comet_ii_seq_alu.sv
// Sequential COMET II ALU: single-cycle arithmetic/logic, bit-serial shifts, valid/ready on both sides.
module comet_ii_seq_alu
  import comet_ii_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       fr,
  output logic             flag_we,
  output logic             reg_we,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [2:0]       fr_q, fr_d;
  logic             flag_we_q, flag_we_d;
  logic             reg_we_q, reg_we_d;

  logic [WIDTH:0]   sum_ext, dif_ext;
  logic             add_ovf, sub_ovf, signed_lt;
  logic [WIDTH-1:0] acc_res;
  logic             acc_of, acc_fwe, acc_rwe;
  logic [2:0]       acc_fr;
  logic [WIDTH-1:0] step_nxt;
  logic             step_out;

  // Shift counts beyond the datapath width behave like a full-width shift
  function automatic logic [CNT_W-1:0] sat_count(input logic [WIDTH-1:0] c);
    if (c >= WIDTH'(WIDTH)) return CNT_W'(WIDTH);
    return c[CNT_W-1:0];
  endfunction

  assign sum_ext   = {1'b0, in0} + {1'b0, in1};
  assign dif_ext   = {1'b0, in0} - {1'b0, in1};
  assign add_ovf   = (in0[WIDTH-1] == in1[WIDTH-1]) && (sum_ext[WIDTH-1] != in0[WIDTH-1]);
  assign sub_ovf   = (in0[WIDTH-1] != in1[WIDTH-1]) && (dif_ext[WIDTH-1] != in0[WIDTH-1]);
  // Sign of the difference is wrong exactly when the subtraction overflowed
  assign signed_lt = dif_ext[WIDTH-1] ^ sub_ovf;

  comet_ii_shift_step #(.WIDTH(WIDTH)) u_step (
    .op    (op_q),
    .val   (val_q),
    .nxt   (step_nxt),
    .shout (step_out)
  );

  // Single-cycle result and flags for everything except multi-bit shifts
  always_comb begin
    acc_res = in0;
    acc_of  = 1'b0;
    acc_fwe = 1'b1;
    acc_rwe = 1'b1;
    case (op)
      OP_LD:   acc_res = in1;
      OP_ADDA: begin acc_res = sum_ext[WIDTH-1:0]; acc_of = add_ovf;          end
      OP_SUBA: begin acc_res = dif_ext[WIDTH-1:0]; acc_of = sub_ovf;          end
      OP_ADDL: begin acc_res = sum_ext[WIDTH-1:0]; acc_of = sum_ext[WIDTH];   end
      OP_SUBL: begin acc_res = dif_ext[WIDTH-1:0]; acc_of = dif_ext[WIDTH];   end
      OP_AND:  acc_res = in0 & in1;
      OP_OR:   acc_res = in0 | in1;
      OP_XOR:  acc_res = in0 ^ in1;
      OP_CPA, OP_CPL: begin acc_res = dif_ext[WIDTH-1:0]; acc_rwe = 1'b0;    end
      OP_SLA, OP_SRA, OP_SLL, OP_SRL: acc_res = in0;
      default: begin acc_fwe = 1'b0; acc_rwe = 1'b0;                         end
    endcase
    acc_fr = {acc_of, acc_res[WIDTH-1], acc_res == '0};
    if (op == OP_CPA) acc_fr[FR_SF] = signed_lt;
    if (op == OP_CPL) acc_fr[FR_SF] = dif_ext[WIDTH];
    if (!acc_fwe)     acc_fr = 3'b000;
  end

  // Sequencer next state and captured operands/outputs
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    val_d     = val_q;
    op_d      = op_q;
    result_d  = result_q;
    fr_d      = fr_q;
    flag_we_d = flag_we_q;
    reg_we_d  = reg_we_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          op_d  = op;
          val_d = in0;
          cnt_d = sat_count(in1);
          if (is_shift(op) && (cnt_d != '0)) begin
            state_d = SHIFT;
          end else begin
            state_d   = DONE;
            result_d  = acc_res;
            fr_d      = acc_fr;
            flag_we_d = acc_fwe;
            reg_we_d  = acc_rwe;
          end
        end
      end
      SHIFT: begin
        val_d = step_nxt;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d   = DONE;
          result_d  = step_nxt;
          fr_d      = {step_out, step_nxt[WIDTH-1], step_nxt == '0};
          flag_we_d = 1'b1;
          reg_we_d  = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and visible outputs; reset clears them without waiting for a clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      result_q  <= '0;
      fr_q      <= 3'b000;
      flag_we_q <= 1'b0;
      reg_we_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      fr_q      <= fr_d;
      flag_we_q <= flag_we_d;
      reg_we_q  <= reg_we_d;
    end
  end

  // Working shift value and latched op; only meaningful while an operation is in flight
  always_ff @(posedge clk) begin
    val_q <= val_d;
    op_q  <= op_d;
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == SHIFT);
  assign result    = result_q;
  assign fr        = fr_q;
  assign flag_we   = flag_we_q;
  assign reg_we    = reg_we_q;

endmodule

// File: doc/comet_ii_seq_alu.md
# comet_ii_seq_alu

Registered, multi-cycle COMET II ALU with a `WIDTH` parameter and valid/ready handshakes on both input and output. It sits between operand fetch and GR/FR writeback. Shifts execute one bit per cycle. It also returns write-enable qualifiers for GR and FR, and CPA reports the true signed comparison result.

## Interface
- `WIDTH`, 16, datapath width in bits; must be ≥ 4.
- `CNT_W`, derived as `$clog2(WIDTH+1)`, width of the shift counter; not overridable.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  high only in IDLE with `rst` low.
- `op`  in  4  COMET II ALU code: NOP 1111, LD 0111, ADDA 1000, SUBA 1001, ADDL 1010, SUBL 1011, AND 1100, OR 1101, XOR 1110, CPA 0000, CPL 0001, SLA 0100, SRA 0101, SLL 0010, SRL 0011.
- `in0`  in  WIDTH  r / r1 operand.
- `in1`  in  WIDTH  r2 / adr+x operand, or the shift count.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts the result.
- `result`  out  WIDTH  operation result.
- `fr`  out  3  {OF, SF, ZF}.
- `flag_we`  out  1  FR is to be updated.
- `reg_we`  out  1  GR is to be written.
- `busy`  out  1  state is SHIFT.

## Operation
- States:
  - IDLE → SHIFT, or IDLE → DONE, on `in_valid && in_ready`.
  - SHIFT → DONE when the counter reaches 0.
  - DONE → IDLE on `out_ready`.
- Operands and `op` are captured at acceptance. Later input changes are ignored.
- LD: `result` = `in1`; OF = 0.
- ADDA/SUBA: two's complement. OF = signed overflow.
- ADDL/SUBL: OF = carry out (ADDL) or borrow (SUBL).
- AND/OR/XOR: OF = 0.
- For all of the above, SF = `result[WIDTH-1]` and ZF = (`result` == 0).
- CPA: SF = 1 iff `$signed(in0) < $signed(in1)`, correct even when the subtraction overflows. ZF = (`in0` == `in1`). OF = 0. `result` = `in0` − `in1`. `reg_we` = 0.
- CPL: SF = 1 iff `in0` < `in1` unsigned. ZF and OF as for CPA. `reg_we` = 0.
- Shifts:
  - Effective count = min(`in1`, WIDTH).
  - SLA keeps bit WIDTH−1 and shifts bits [WIDTH−2:0] left, zero fill.
  - SRA shifts right with sign fill.
  - SLL shifts left, zero fill.
  - SRL shifts right, zero fill.
  - OF = the last bit shifted out (out of bit WIDTH−2 for SLA).
  - Count 0: `result` = `in0`, OF = 0.
  - SF and ZF come from the final `result`.
- NOP and undefined code 0110: complete with `result` = `in0`, `fr` = 000, `flag_we` = 0, `reg_we` = 0.
- `flag_we` = 1 for all defined ops except NOP.
- `reg_we` = 1 for all defined ops except NOP, CPA and CPL.

## Timing
- Reset values: `out_valid` 0, `result` 0, `fr` 000, `flag_we` 0, `reg_we` 0, `busy` 0, state IDLE. `in_ready` is 0 while `rst` is high and 1 in the first cycle after release.
- Non-shift ops and zero-count shifts: `out_valid` rises 1 cycle after the acceptance edge.
- Shift with effective count n: n cycles in SHIFT, one bit per cycle. `out_valid` rises n+1 cycles after acceptance.
- `busy` = 1 exactly during SHIFT.
- `result`, `fr`, `flag_we` and `reg_we` are registered. They are stable whenever `out_valid` = 1 and held until the handshake.
- Output handshake:
  - `out_valid` stays high until `out_ready`.
  - If `out_ready` is already high on the first `out_valid` cycle, the handshake completes that cycle and `in_ready` = 1 on the next.
- One operation is outstanding at a time. `in_valid` during SHIFT or DONE is ignored; it is neither queued nor lost silently into state.
- Reset asserted mid-SHIFT or in DONE aborts the operation immediately. Outputs go to their reset values with no clock edge required.

## Structure
- Package `comet_ii_pkg` holds:
  - ALU op code constants, shared with the decoder.
  - FR bit index constants (OF = 2, SF = 1, ZF = 0).
  - The state enum {IDLE, SHIFT, DONE}.
- Sub-module `comet_ii_shift_step`: combinational one-bit step for SLA/SRA/SLL/SRL. It returns the next value and the bit shifted out. It is instantiated once; the SHIFT state reuses it every cycle.

## Test plan
- ADDA, `in0` 0x7FFF, `in1` 0x0001 → `result` 0x8000, `fr` 110, `flag_we` 1, `reg_we` 1, `out_valid` 1 cycle after accept.
- SUBL, `in0` 0x0001, `in1` 0x0002 → `result` 0xFFFF, `fr` 110.
- CPA, `in0` 0x8000, `in1` 0x0001 → `fr` 010 (signed less despite overflow), `reg_we` 0.
- CPL, same operands → `fr` 000.
- SRA, `in0` 0x8003, count 2 → `result` 0xE000, `fr` 110, `busy` for 2 cycles, `out_valid` 3 cycles after accept.
- SLL, `in0` 0x0001, count 20 (saturates to 16) → `result` 0x0000, `fr` 101, `out_valid` 17 cycles after accept.
- SLA, `in0` 0x8001, count 0 → `result` 0x8001, `fr` 010.
- Backpressure and reset:
  - Hold `out_ready` 0 for 5 cycles → `result`/`fr` stable, `in_ready` 0, and a new `in_valid` is ignored.
  - Release `out_ready` → `in_ready` 1 next cycle.
  - Assert `rst` mid-SHIFT → `out_valid` 0 and `busy` 0 asynchronously.
